uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among N_REQ byte-producing requesters, e.g. CPU console, debug dump and trace units.
- Arbitrates round-robin and issues one tx_start pulse per granted byte.
- Tracks frame completion from the transmitter's busy flag.
- Enforces an idle guard time between frames. Sits between the requesters and the uart_tx start/data/busy interface.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- GUARD_CYC, 16, idle clk cycles inserted after each frame before the next grant; 0 disables the guard.
- START_TO, 8, max clk cycles to wait for tx_busy to rise after tx_start before declaring a start failure.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester level request; req_data slice must be stable while high
- req_data  in  8*N_REQ  byte of requester i at [8i+7:8i]
- gnt  out  N_REQ  one-cycle pulse: requester's byte latched, may drop req or present the next byte
- done  out  N_REQ  one-cycle pulse: requester's frame finished on the line
- err  out  1  one-cycle pulse: start timeout, tx_busy never rose
- owner  out  clog2(N_REQ)  index of the current or last granted requester
- arb_busy  out  1  high in every state except IDLE
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to the transmitter; held from grant until return to IDLE
- tx_busy  in  1  transmitter busy flag

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - gnt, done, err, tx_start, tx_data, owner and arb_busy all go to 0.
  - Round-robin pointer goes to N_REQ-1, so requester 0 wins first.
  - Reset mid-frame aborts silently: no done or err pulse. The transmitter is reset separately.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE:
  - If req is non-zero at edge T, the winner w is the first set bit searching upward from (ptr+1) mod N_REQ with wrap.
  - At T+1: gnt[w]=1, tx_start=1, tx_data=req_data[w], owner=w, ptr=w, arb_busy=1, state goes to WAIT_BUSY, timeout counter loads START_TO.
  - Latency from req to tx_start is 1 cycle. No req means stay in IDLE with all pulses low.
- WAIT_BUSY:
  - gnt and tx_start return to 0 after the single cycle.
  - tx_busy=1 sends the state to WAIT_DONE.
  - Otherwise the counter decrements. On reaching 0: err=1 and done[owner]=1 for one cycle, state goes to GUARD.
- WAIT_DONE:
  - When tx_busy is sampled 0 (falling edge of busy), done[owner]=1 for one cycle.
  - The guard counter loads GUARD_CYC and the state goes to GUARD. If GUARD_CYC=0, go directly to IDLE instead.
  - tx_end is not used; completion comes only from tx_busy.
- GUARD:
  - The counter decrements each cycle. At 0, go to IDLE and set arb_busy=0.
  - Requests arriving during GUARD are held off and arbitrated on the first IDLE cycle.
- Arbitration timing:
  - Back-to-back: the earliest next tx_start is GUARD_CYC+1 cycles after the done pulse.
  - A requester holding req after its gnt is treated as a new request. It gets the lowest priority next round because ptr=w.
- Simultaneous events:
  - All requesters set: grant order 0,1,2,3,0,...
  - A req change in the same cycle as the IDLE decision uses the sampled value.
  - A req drop after the decision edge does not cancel the grant.
- Invariants:
  - gnt, done and tx_start are at most one-hot, and never high for two consecutive cycles.
  - Exactly one done per gnt, except when aborted by reset.
- Counters are sized to clog2(max(GUARD_CYC, START_TO)+1) bits and never wrap below 0.

Optional Feature:
- Macro: UART_ARB_PRIO0_EN.
- Defined: requester 0 has fixed top priority. If req[0]=1 in IDLE it wins regardless of ptr. The other requesters rotate round-robin among themselves. ptr is updated only when a requester other than 0 wins.
- Undefined: pure round-robin across all N_REQ, as in Behaviour.

Test Plan:
- Single request, with a transmitter model that asserts busy 1 cycle after start and drops it 2610 cycles later: req=4'b0100, req_data[23:16]=8'hA5 -> gnt=4'b0100 and tx_start=1 one cycle later, tx_data=8'hA5; done=4'b0100 on the busy fall; next IDLE after 16 guard cycles.
- All four requesters held high with bytes 0x10..0x13 -> tx_data order 0x10,0x11,0x12,0x13,0x10; each gnt one-hot; each tx_start exactly GUARD_CYC+1 cycles after the previous done.
- Transmitter model never raises busy -> err=1 and done[owner]=1 exactly START_TO cycles after WAIT_BUSY entry; next request then served normally.
- rst=0 asserted in WAIT_DONE -> next cycle all outputs 0, no done pulse; requester 0 granted first after release.
- GUARD_CYC=0 build, req[1] held high -> tx_start re-issued 1 cycle after each done, tx_data stable for the whole frame.
- UART_ARB_PRIO0_EN defined, req=4'b1110 then req[0] rises during requester 1's frame -> next grant goes to requester 0, then requester 2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter among N_REQ byte producers. Requests are
//   arbitrated round-robin; each grant issues a single tx_start pulse, frame
//   completion is taken from the falling edge of tx_busy, and an idle guard
//   time is inserted between frames. A start that never raises tx_busy is
//   reported on err after START_TO cycles.
//
//   Optional build macro: UART_ARB_PRIO0_EN
//     defined   - requester 0 has fixed top priority, others rotate
//     undefined - pure round-robin across all requesters
//
//   Ports
//     clk       system clock
//     rst       synchronous active-low reset
//     req       per-requester level request
//     req_data  byte of requester i at [8i+7:8i], stable while req[i] high
//     gnt       one-cycle pulse, requester's byte has been latched
//     done      one-cycle pulse, requester's frame finished (or timed out)
//     err       one-cycle pulse, tx_busy never rose after tx_start
//     owner     index of the current or last granted requester
//     arb_busy  high whenever the arbiter is not idle
//     tx_start  one-cycle start pulse to the transmitter
//     tx_data   byte to the transmitter, held from grant to return to idle
//     tx_busy   transmitter busy flag
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int GUARD_CYC = 16,
    parameter int START_TO  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       arb_busy,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy
);

    localparam int OW   = $clog2(N_REQ);
    localparam int CMAX = (GUARD_CYC > START_TO) ? GUARD_CYC : START_TO;
    localparam int CW   = $clog2(((CMAX > 1) ? CMAX : 1) + 1);

    localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

`ifdef UART_ARB_PRIO0_EN
    localparam logic PRIO0_EN = 1'b1;
`else
    localparam logic PRIO0_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GUARD     = 2'd3
    } state_t;

    state_t          state_r;
    logic [OW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;

    logic [OW-1:0]   win_s;
    logic            found_s;
    logic [OW-1:0]   cand_s;

    // Winner search: first set request scanning upward from ptr+1 with wrap.
    // With the priority build, requester 0 preempts and is skipped in the scan.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        if (PRIO0_EN && req[0]) begin
            found_s = 1'b1;
            win_s   = '0;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand_s = OW'((int'(ptr_r) + k) % N_REQ);
                if (!found_s && req[cand_s] && (!PRIO0_EN || (cand_s != '0))) begin
                    found_s = 1'b1;
                    win_s   = cand_s;
                end
            end
        end
    end

    // Arbiter FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= OW'(N_REQ - 1);
            cnt_r    <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            owner    <= '0;
            arb_busy <= 1'b0;
        end else begin
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt      <= ONE_HOT << win_s;
                        tx_start <= 1'b1;
                        tx_data  <= req_data[{win_s, 3'b000} +: 8];
                        owner    <= win_s;
                        arb_busy <= 1'b1;
                        cnt_r    <= CW'(START_TO);
                        state_r  <= ST_WAIT_BUSY;
                        // Requester 0 in the priority build does not move the rotation
                        if (!PRIO0_EN || (win_s != '0)) begin
                            ptr_r <= win_s;
                        end else begin
                            ptr_r <= ptr_r;
                        end
                    end else begin
                        arb_busy <= 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (cnt_r <= CW'(1)) begin
                        // Transmitter never acknowledged: close the frame with err
                        err  <= 1'b1;
                        done <= ONE_HOT << owner;
                        if (GUARD_CYC == 0) begin
                            state_r  <= ST_IDLE;
                            arb_busy <= 1'b0;
                        end else begin
                            cnt_r   <= CW'(GUARD_CYC);
                            state_r <= ST_GUARD;
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        done <= ONE_HOT << owner;
                        if (GUARD_CYC == 0) begin
                            state_r  <= ST_IDLE;
                            arb_busy <= 1'b0;
                        end else begin
                            cnt_r   <= CW'(GUARD_CYC);
                            state_r <= ST_GUARD;
                        end
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_GUARD: begin
                    // Last guard cycle: become idle so the next edge can grant
                    if (cnt_r <= CW'(1)) begin
                        cnt_r    <= '0;
                        state_r  <= ST_IDLE;
                        arb_busy <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. A cycle-indexed reference model
//   computes, for every clock edge, the expected pulses and held outputs from
//   grant times, transmitter busy windows and guard lengths. The transmitter
//   is modelled as a busy window scheduled relative to each expected grant.
//   Define TB_GUARD0 to build the bench and DUT with GUARD_CYC=0.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int S = 8;
`ifdef TB_GUARD0
    localparam int G = 0;
`else
    localparam int G = 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_data;
    logic             tx_busy;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             err;
    logic [1:0]       owner;
    logic             arb_busy;
    logic             tx_start;
    logic [7:0]       tx_data;

    uart_tx_arbiter #(.N_REQ(N), .GUARD_CYC(G), .START_TO(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .owner    (owner),
        .arb_busy (arb_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          edge_n  = 0;
    int          m_ptr   = N - 1;
    bit          m_on    = 1'b0;
    bit          m_frame = 1'b0;
    bit          m_to    = 1'b0;
    bit          m_dchk  = 1'b0;
    int          m_done_e = 0;
    int          m_idle_e = 0;
    int          m_owner = 0;
    logic [7:0]  m_data  = 8'h00;
    int          b_lo    = 1;
    int          b_hi    = 0;
    int          tx_delay = 1;
    int          tx_len   = 4;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    bit          e_err;
    bit          e_start;

    // observations of the DUT (used against constants only)
    int          last_done_obs = -1;
    logic [7:0]  st_q[$];
    int          gap_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        int idx;
`ifdef UART_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            idx = (p + k) % N;
`ifdef UART_ARB_PRIO0_EN
            if (idx != 0 && r[idx]) return idx;
`else
            if (r[idx]) return idx;
`endif
        end
        return -1;
    endfunction

    // One clock edge: drive the transmitter, advance the model, compare.
    task automatic step();
        logic           rs;
        logic [N-1:0]   rq;
        logic [8*N-1:0] rd;
        int             w;
        edge_n++;
        tx_busy = (edge_n >= b_lo) && (edge_n <= b_hi);
        rs = rst;
        rq = req;
        rd = req_data;
        @(posedge clk);
        #1;
        e_gnt   = '0;
        e_done  = '0;
        e_err   = 1'b0;
        e_start = 1'b0;
        if (!rs) begin
            m_ptr = N - 1; m_on = 1'b0; m_frame = 1'b0; m_owner = 0;
            m_data = 8'h00; m_dchk = 1'b1; b_lo = 1; b_hi = 0;
        end else if (m_on) begin
            if (m_frame && edge_n == m_done_e) begin
                e_done[m_owner] = 1'b1;
                e_err   = m_to;
                m_frame = 1'b0;
            end
            if (edge_n == m_idle_e) begin
                m_on = 1'b0;
                m_dchk = 1'b0;
            end
        end else if (rq != '0) begin
            w = pick(rq, m_ptr);
            e_gnt[w] = 1'b1;
            e_start  = 1'b1;
            m_owner  = w;
            m_data   = rd[8*w +: 8];
`ifdef UART_ARB_PRIO0_EN
            if (w != 0) m_ptr = w;
`else
            m_ptr = w;
`endif
            m_on = 1'b1; m_frame = 1'b1; m_dchk = 1'b1;
            if (tx_delay >= 1 && tx_delay <= S) begin
                b_lo = edge_n + tx_delay;
                b_hi = b_lo + tx_len - 1;
                m_done_e = b_hi + 1;
                m_to = 1'b0;
            end else begin
                b_lo = 1; b_hi = 0;
                m_done_e = edge_n + S;
                m_to = 1'b1;
            end
            m_idle_e = m_done_e + G;
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("tx_start", 32'(tx_start), 32'(e_start));
        chk("arb_busy", 32'(arb_busy), 32'(m_on));
        chk("owner", 32'(owner), 32'(m_owner));
        if (m_dchk) chk("tx_data", 32'(tx_data), 32'(m_data));
        if (!rs) last_done_obs = -1;
        if (|done === 1'b1) last_done_obs = edge_n;
        if (tx_start === 1'b1) begin
            st_q.push_back(tx_data);
            if (last_done_obs >= 0) gap_q.push_back(edge_n - last_done_obs);
        end
    endtask

    task automatic run_until_idle(input int maxc);
        int c = 0;
        while (m_on && c < maxc) begin
            step();
            c++;
        end
        chk("idle_bound", 32'(m_on), 32'(0));
    endtask

    task automatic run_until_grant(input int maxc);
        int c = 0;
        e_start = 1'b0;
        while (!e_start && c < maxc) begin
            step();
            c++;
        end
        chk("grant_bound", 32'(e_start), 32'(1));
    endtask

    task automatic rand_react();
        for (int i = 0; i < N; i++) begin
            if (e_gnt[i]) begin
                if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                else req_data[8*i +: 8] = 8'($urandom);
            end else if (!req[i] && $urandom_range(9, 0) == 0) begin
                req_data[8*i +: 8] = 8'($urandom);
                req[i] = 1'b1;
            end
        end
        tx_delay = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(S, 1));
        tx_len   = int'($urandom_range(12, 1));
    endtask

    initial begin
        int de;
        int ie;
        int ge;
        int ee;
        int c;
        logic [7:0] exp_ord [5];

        rst = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        chk("rst_arb_busy", 32'(arb_busy), 32'(0));

        // single request, long frame
        tx_delay = 1; tx_len = 2610;
        req = 4'b0100; req_data[23:16] = 8'hA5;
        step();
        chk("t1_gnt", 32'(gnt), 32'(4'b0100));
        chk("t1_data", 32'(tx_data), 32'(8'hA5));
        req = '0;
        de = -1; ie = -1; c = 0;
        while (ie < 0 && c < 4000) begin
            step();
            if (|done === 1'b1) begin
                de = edge_n;
                chk("t1_done", 32'(done), 32'(4'b0100));
            end
            if (de >= 0 && arb_busy === 1'b0) ie = edge_n;
            c++;
        end
        chk("t1_guard_len", 32'(ie - de), 32'(G));

        // reset in the middle of a frame
        tx_delay = 1; tx_len = 50;
        req = 4'b1000; req_data[31:24] = 8'h77;
        run_until_grant(10);
        req = '0;
        repeat (5) step();
        rst = 1'b0;
        step();
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(arb_busy), 32'(0));
        rst = 1'b1;

        // all four requesters held high
        tx_len = 30;
        req = 4'hF; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        st_q.delete(); gap_q.delete();
        c = 0;
        while (st_q.size() < 5 && c < 1000) begin
            step();
            c++;
        end
        req = '0;
        run_until_idle(200);
`ifdef UART_ARB_PRIO0_EN
        exp_ord = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
        exp_ord = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
        chk("rr_count", 32'(st_q.size()), 32'(5));
        for (int i = 0; i < 5 && i < st_q.size(); i++) chk("rr_order", 32'(st_q[i]), 32'(exp_ord[i]));
        chk("rr_gaps", 32'(gap_q.size()), 32'(4));
        foreach (gap_q[i]) chk("rr_gap", 32'(gap_q[i]), 32'(G + 1));

        // start timeout, then normal service
        tx_delay = 0;
        req = 4'b0010; req_data[15:8] = 8'h3C;
        ge = -1; ee = -1; c = 0;
        while (ee < 0 && c < 100) begin
            step();
            if (tx_start === 1'b1) begin
                ge = edge_n;
                req = '0;
            end
            if (err === 1'b1) begin
                ee = edge_n;
                chk("to_done", 32'(done), 32'(4'b0010));
            end
            c++;
        end
        chk("to_latency", 32'(ee - ge), 32'(S));
        run_until_idle(100);
        tx_delay = 1; tx_len = 5;
        req = 4'b0001; req_data[7:0] = 8'h5A;
        run_until_grant(10);
        chk("to_next_data", 32'(tx_data), 32'(8'h5A));
        req = '0;
        run_until_idle(100);

        // requester 0 rises during requester 1's frame
        tx_delay = 1; tx_len = 40;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b1110;
        st_q.delete();
        run_until_grant(10);
        chk("p_first", 32'(tx_data), 32'(8'hB1));
        req = 4'b1100;
        repeat (10) step();
        req = 4'b1101;
        c = 0;
        while (st_q.size() < 3 && c < 500) begin
            step();
            req = req & ~e_gnt;
            c++;
        end
        chk("p_count", 32'(st_q.size()), 32'(3));
`ifdef UART_ARB_PRIO0_EN
        if (st_q.size() >= 3) begin
            chk("p_second", 32'(st_q[1]), 32'(8'hA0));
            chk("p_third", 32'(st_q[2]), 32'(8'hC2));
        end
`else
        if (st_q.size() >= 3) begin
            chk("p_second", 32'(st_q[1]), 32'(8'hC2));
            chk("p_third", 32'(st_q[2]), 32'(8'hD3));
        end
`endif
        req = '0;
        run_until_idle(200);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            rand_react();
        end
        req = '0;
        run_until_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
